// File: rtl/iq_avg_snap_accum_if.sv
// Sample stream and snapshot BRAM write port of iq_avg_snap_accum.
// The master is the sample source and BRAM sink; the slave is the averager.
interface iq_avg_snap_accum_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CH_W   = 8
);
  logic                     in_valid;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_i;
  logic signed [DATA_W-1:0] in_q;
  logic                     bram_we;
  logic [ADDR_W-1:0]        bram_addr;
  logic [2*DATA_W-1:0]      bram_data;

  modport master (
    output in_valid, in_ch, in_i, in_q,
    input  bram_we, bram_addr, bram_data
  );

  modport slave (
    input  in_valid, in_ch, in_i, in_q,
    output bram_we, bram_addr, bram_data
  );
endinterface

// File: rtl/iq_avg_snap_accum.sv
// Averages 2^navg I/Q samples of one channel and fills a snapshot BRAM until full.
// Define IQ_AVG_ROUND_EN for round-half-up averages instead of floor.
module iq_avg_snap_accum #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LOG_MAX_AVG = 10,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned CH_W        = 8
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [31:0]         ctrl_word,
  iq_avg_snap_accum_if.slave  bus,
  output logic                busy,
  output logic                done
);

`ifdef IQ_AVG_ROUND_EN
  localparam int unsigned Guard = 1;
`else
  localparam int unsigned Guard = 0;
`endif
  localparam int unsigned AW = DATA_W + LOG_MAX_AVG + Guard;
  localparam int unsigned CW = LOG_MAX_AVG + 1;
  localparam logic [3:0]  MaxNavg = 4'(LOG_MAX_AVG);

  typedef enum logic [1:0] {StIdle, StAccum, StWrite, StDone} state_e;

  state_e                state_q;
  logic                  arm_d;
  logic [CH_W-1:0]       sel_ch_q;
  logic [3:0]            navg_q;
  logic signed [AW-1:0]  acc_i_q;
  logic signed [AW-1:0]  acc_q_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_W-1:0]     addr_q;

  logic                  arm;
  logic                  arm_edge;
  logic                  match;
  logic                  complete;
  logic                  last_addr;
  logic [3:0]            navg_cap;
  logic [CW-1:0]         target;
  logic [CW-1:0]         cnt_sum;
  logic signed [AW-1:0]  samp_i;
  logic signed [AW-1:0]  samp_q;
  logic signed [AW-1:0]  base_i;
  logic signed [AW-1:0]  base_q;
  logic signed [AW-1:0]  sum_i;
  logic signed [AW-1:0]  sum_q;
  logic signed [AW-1:0]  sum_r_i;
  logic signed [AW-1:0]  sum_r_q;
`ifdef IQ_AVG_ROUND_EN
  logic signed [AW-1:0]  rnd;
`endif
  logic [DATA_W-1:0]     avg_i;
  logic [DATA_W-1:0]     avg_q;

  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_word[31:16], ctrl_word[7:5]};

  always_comb begin
    arm       = ctrl_word[4];
    arm_edge  = arm & ~arm_d;
    match     = bus.in_valid && (bus.in_ch == sel_ch_q);
    navg_cap  = (ctrl_word[3:0] > MaxNavg) ? MaxNavg : ctrl_word[3:0];
    target    = CW'(1) << navg_q;
    last_addr = (addr_q == {ADDR_W{1'b1}});

    samp_i = {{(AW-DATA_W){bus.in_i[DATA_W-1]}}, bus.in_i};
    samp_q = {{(AW-DATA_W){bus.in_q[DATA_W-1]}}, bus.in_q};

    // In WRITE the accumulator already belongs to the finished average, so the
    // current sample seeds a fresh one.
    base_i  = (state_q == StWrite) ? '0 : acc_i_q;
    base_q  = (state_q == StWrite) ? '0 : acc_q_q;
    cnt_sum = ((state_q == StWrite) ? '0 : cnt_q) + 1'b1;
    sum_i   = base_i + samp_i;
    sum_q   = base_q + samp_q;

`ifdef IQ_AVG_ROUND_EN
    rnd     = (navg_q == 4'd0) ? '0 : (AW'(1) << (navg_q - 4'd1));
    sum_r_i = sum_i + rnd;
    sum_r_q = sum_q + rnd;
`else
    sum_r_i = sum_i;
    sum_r_q = sum_q;
`endif
    avg_i = DATA_W'(sum_r_i >>> navg_q);
    avg_q = DATA_W'(sum_r_q >>> navg_q);

    complete = match && (cnt_sum == target);
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q       <= StIdle;
      arm_d         <= 1'b1;
      sel_ch_q      <= '0;
      navg_q        <= '0;
      acc_i_q       <= '0;
      acc_q_q       <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      bus.bram_we   <= 1'b0;
      bus.bram_addr <= '0;
      bus.bram_data <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      arm_d       <= arm;
      bus.bram_we <= 1'b0;
      case (state_q)
        StIdle: begin
          if (arm_edge) begin
            sel_ch_q <= ctrl_word[15:8];
            navg_q   <= navg_cap;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            state_q  <= StAccum;
            busy     <= 1'b1;
          end
        end
        StAccum: begin
          if (!arm) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (complete) begin
            state_q       <= StWrite;
            bus.bram_we   <= 1'b1;
            bus.bram_addr <= addr_q;
            bus.bram_data <= {avg_i, avg_q};
          end else if (match) begin
            acc_i_q <= sum_i;
            acc_q_q <= sum_q;
            cnt_q   <= cnt_sum;
          end
        end
        StWrite: begin
          if (last_addr) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            addr_q <= addr_q + 1'b1;
            if (complete) begin
              bus.bram_we   <= 1'b1;
              bus.bram_addr <= addr_q + 1'b1;
              bus.bram_data <= {avg_i, avg_q};
            end else begin
              state_q <= StAccum;
              acc_i_q <= match ? sum_i : '0;
              acc_q_q <= match ? sum_q : '0;
              cnt_q   <= match ? cnt_sum : '0;
            end
          end
        end
        StDone: begin
          if (!arm) begin
            state_q <= StIdle;
            done    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_avg_snap_accum.sv
// Randomized self-checking bench for iq_avg_snap_accum against a group-average model.
module tb_iq_avg_snap_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  iq_avg_snap_accum_if #(.DATA_W(16), .ADDR_W(8), .CH_W(8)) bus ();

  iq_avg_snap_accum #(
    .DATA_W(16), .LOG_MAX_AVG(10), .ADDR_W(8), .CH_W(8)
  ) dut (
    .user_clk (clk),
    .user_rst (rst),
    .ctrl_word(ctrl),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {int addr; int i; int q; int cyc;} wr_t;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  wr_t wq[$];
  wr_t exq[$];

  // Reference model: groups of 2^navg matching samples, one write per group.
  bit     m_on = 1'b0;
  int     m_ch, m_navg, m_addr, m_n;
  longint m_si, m_sq;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.bram_we === 1'b1)
      wq.push_back('{addr: int'(bus.bram_addr), i: int'($signed(bus.bram_data[31:16])),
                     q: int'($signed(bus.bram_data[15:0])), cyc: cyc});
  end

  function automatic int avg_of(input longint sum, input int n);
    longint d;
    longint s;
    longint qt;
    logic signed [15:0] t;
    d = longint'(1) << n;
    s = sum;
`ifdef IQ_AVG_ROUND_EN
    if (n > 0) s = s + d / 2;
`endif
    qt = s / d;
    if ((s % d != 0) && (s < 0)) qt = qt - 1;
    t = qt[15:0];
    return int'(t);
  endfunction

  task automatic send(input bit v, input int ch, input int i, input int q);
    bus.in_valid = v;
    bus.in_ch    = 8'(ch);
    bus.in_i     = 16'(i);
    bus.in_q     = 16'(q);
    if (m_on && v && ch == m_ch && m_addr < 256) begin
      m_si += i;
      m_sq += q;
      m_n++;
      if (m_n == (1 << m_navg)) begin
        exq.push_back('{addr: m_addr, i: avg_of(m_si, m_navg), q: avg_of(m_sq, m_navg),
                        cyc: cyc + 1});
        m_addr++;
        m_si = 0;
        m_sq = 0;
        m_n  = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 0, 0, 0);
  endtask

  task automatic arm_set(input bit a, input int ch, input int ln);
    ctrl = {16'h0, 8'(ch), 3'b000, a, 4'(ln)};
    m_on = a;
    if (a) begin
      m_ch   = ch;
      m_navg = (ln > 10) ? 10 : ln;
      m_addr = 0;
      m_n    = 0;
      m_si   = 0;
      m_sq   = 0;
    end
    send(1'b0, 0, 0, 0);
  endtask

  task automatic test_reset;
    ctrl = 32'h0000_0010;
    rst  = 1'b1;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_i = '0; bus.in_q = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.bram_we, busy, done, bus.bram_addr, bus.bram_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b busy=%b done=%b addr=%0d data=%h, want all 0",
               bus.bram_we, busy, done, bus.bram_addr, bus.bram_data);
    end
    rst = 1'b0;
    wq.delete(); exq.delete();
    // Arm already high out of reset must not start a capture.
    for (int k = 0; k < 20; k++) send(1'b1, 0, k, k);
    checks++;
    if (busy !== 1'b0 || wq.size() != 0) begin
      errors++;
      $display("FAIL reset_arm_high: got busy=%b writes=%0d, want busy=0 writes=0",
               busy, wq.size());
    end
    arm_set(1'b0, 0, 0);
  endtask

  task automatic test_average;
    int qexp;
`ifdef IQ_AVG_ROUND_EN
    qexp = -4;
`else
    qexp = -5;
`endif
    wq.delete(); exq.delete();
    arm_set(1'b1, 5, 2);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL avg_busy: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    send(1'b1, 5, 100, -4);
    send(1'b1, 5, 104, -4);
    send(1'b1, 5, 108, -4);
    send(1'b1, 5, 112, -5);
    idle(3);
    checks++;
    if (wq.size() != 1 || exq.size() != 1) begin
      errors++;
      $display("FAIL avg_count: got %0d writes, want 1", wq.size());
    end else begin
      checks++;
      if (wq[0] !== exq[0] || wq[0].addr != 0 || wq[0].i != 106 || wq[0].q != qexp) begin
        errors++;
        $display("FAIL avg_write: got addr=%0d i=%0d q=%0d cyc=%0d, want addr=0 i=106 q=%0d cyc=%0d",
                 wq[0].addr, wq[0].i, wq[0].q, wq[0].cyc, qexp, exq[0].cyc);
      end
    end
    arm_set(1'b0, 0, 0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL avg_disarm: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_channel_filter;
    int ch;
    wq.delete(); exq.delete();
    arm_set(1'b1, 5, 3);
    for (int k = 0; k < 64; k++) begin
      ch = (k % 3) + 4;
      if (ch == 5) send(1'b1, ch, int'($signed(16'($urandom))), int'($signed(16'($urandom))));
      else         send(1'b1, ch, 32767, -32768);
    end
    idle(3);
    checks++;
    if (wq.size() != exq.size() || exq.size() != 2) begin
      errors++;
      $display("FAIL filter_count: got %0d writes, want %0d", wq.size(), exq.size());
    end
    for (int k = 0; k < wq.size() && k < exq.size(); k++) begin
      checks++;
      if (wq[k] !== exq[k]) begin
        errors++;
        $display("FAIL filter_write[%0d]: got a=%0d i=%0d q=%0d c=%0d, want a=%0d i=%0d q=%0d c=%0d",
                 k, wq[k].addr, wq[k].i, wq[k].q, wq[k].cyc,
                 exq[k].addr, exq[k].i, exq[k].q, exq[k].cyc);
      end
    end
    arm_set(1'b0, 0, 0);
  endtask

  task automatic test_random_avg;
    int sel, ch;
    for (int t = 0; t < 4; t++) begin
      wq.delete(); exq.delete();
      sel = $urandom_range(0, 255);
      arm_set(1'b1, sel, $urandom_range(0, 4));
      for (int k = 0; k < 80; k++) begin
        ch = ($urandom_range(0, 1) == 1) ? sel : $urandom_range(0, 255);
        send($urandom_range(0, 4) != 0, ch, int'($signed(16'($urandom))),
             int'($signed(16'($urandom))));
      end
      idle(2);
      arm_set(1'b0, 0, 0);
      idle(2);
      checks++;
      if (wq.size() != exq.size()) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d writes, want %0d", t, wq.size(), exq.size());
      end
      for (int k = 0; k < wq.size() && k < exq.size(); k++) begin
        checks++;
        if (wq[k] !== exq[k]) begin
          errors++;
          $display("FAIL rand_write[%0d.%0d]: got a=%0d i=%0d q=%0d c=%0d, want a=%0d i=%0d q=%0d c=%0d",
                   t, k, wq[k].addr, wq[k].i, wq[k].q, wq[k].cyc,
                   exq[k].addr, exq[k].i, exq[k].q, exq[k].cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    wq.delete(); exq.delete();
    arm_set(1'b1, 3, 0);
    for (int n = 0; n < 256; n++) send(1'b1, 3, n, -n);
    send(1'b1, 3, 999, 999);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done: got done=%b busy=%b, want done=1 busy=0", done, busy);
    end
    for (int n = 0; n < 10; n++) send(1'b1, 3, n, n);
    checks++;
    if (wq.size() != 256 || exq.size() != 256) begin
      errors++;
      $display("FAIL full_count: got %0d writes, want 256", wq.size());
    end
    for (int k = 0; k < wq.size() && k < exq.size(); k++) begin
      checks++;
      if (wq[k] !== exq[k]) begin
        errors++;
        $display("FAIL full_write[%0d]: got a=%0d i=%0d q=%0d c=%0d, want a=%0d i=%0d q=%0d c=%0d",
                 k, wq[k].addr, wq[k].i, wq[k].q, wq[k].cyc,
                 exq[k].addr, exq[k].i, exq[k].q, exq[k].cyc);
      end
    end
    arm_set(1'b0, 0, 0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL full_release: got done=%b, want 0", done);
    end
  endtask

  task automatic test_abort_rearm;
    wq.delete(); exq.delete();
    arm_set(1'b1, 7, 2);
    send(1'b1, 7, 1000, 1000);
    send(1'b1, 7, 2000, 2000);
    arm_set(1'b0, 0, 0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got busy=%b, want 0", busy);
    end
    idle(4);
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL abort_nowrite: got %0d writes, want 0", wq.size());
    end
    arm_set(1'b1, 9, 2);
    for (int k = 0; k < 4; k++) send(1'b1, 7, 30000, 30000);
    for (int k = 0; k < 4; k++)
      send(1'b1, 9, int'($signed(16'($urandom))), int'($signed(16'($urandom))));
    idle(3);
    checks++;
    if (wq.size() != 1 || exq.size() != 1) begin
      errors++;
      $display("FAIL rearm_count: got %0d writes, want 1", wq.size());
    end else begin
      checks++;
      if (wq[0] !== exq[0] || wq[0].addr != 0) begin
        errors++;
        $display("FAIL rearm_write: got a=%0d i=%0d q=%0d c=%0d, want a=%0d i=%0d q=%0d c=%0d",
                 wq[0].addr, wq[0].i, wq[0].q, wq[0].cyc,
                 exq[0].addr, exq[0].i, exq[0].q, exq[0].cyc);
      end
    end
    arm_set(1'b0, 0, 0);
  endtask

  task automatic test_clamp;
    wq.delete(); exq.delete();
    arm_set(1'b1, 2, 15);
    for (int k = 0; k < 1023; k++) send(1'b1, 2, 1000, 1000);
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL clamp_early: got %0d writes before sample 1024, want 0", wq.size());
    end
    send(1'b1, 2, 1000, 1000);
    for (int k = 0; k < 1024; k++) send(1'b1, 2, -32768, -32768);
    idle(3);
    checks++;
    if (wq.size() != 2 || exq.size() != 2) begin
      errors++;
      $display("FAIL clamp_count: got %0d writes, want 2", wq.size());
    end else begin
      checks++;
      if (wq[0] !== exq[0] || wq[0].i != 1000 || wq[0].q != 1000) begin
        errors++;
        $display("FAIL clamp_pos: got a=%0d i=%0d q=%0d c=%0d, want a=0 i=1000 q=1000 c=%0d",
                 wq[0].addr, wq[0].i, wq[0].q, wq[0].cyc, exq[0].cyc);
      end
      checks++;
      if (wq[1] !== exq[1] || wq[1].i != -32768 || wq[1].q != -32768) begin
        errors++;
        $display("FAIL clamp_neg: got a=%0d i=%0d q=%0d c=%0d, want a=1 i=-32768 q=-32768 c=%0d",
                 wq[1].addr, wq[1].i, wq[1].q, wq[1].cyc, exq[1].cyc);
      end
    end
    arm_set(1'b0, 0, 0);
  endtask

  task automatic test_reset_mid;
    wq.delete(); exq.delete();
    arm_set(1'b1, 1, 2);
    send(1'b1, 1, 500, 500);
    send(1'b1, 1, 600, 600);
    m_on = 1'b0;
    rst  = 1'b1;
    send(1'b1, 1, 700, 700);
    checks++;
    if ({bus.bram_we, busy, done, bus.bram_addr, bus.bram_data} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got we=%b busy=%b done=%b addr=%0d data=%h, want all 0",
               bus.bram_we, busy, done, bus.bram_addr, bus.bram_data);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) send(1'b1, 1, 800, 800);
    idle(2);
    checks++;
    if (wq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got writes=%0d busy=%b, want writes=0 busy=0",
               wq.size(), busy);
    end
    arm_set(1'b0, 0, 0);
    arm_set(1'b1, 1, 2);
    for (int k = 0; k < 4; k++) send(1'b1, 1, 40 * k, -3 * k);
    idle(3);
    checks++;
    if (wq.size() != 1 || exq.size() != 1 || wq[0] !== exq[0]) begin
      errors++;
      $display("FAIL midreset_rearm: got %0d writes (first i=%0d), want 1 write a=0 i=%0d",
               wq.size(), (wq.size() > 0) ? wq[0].i : 0, (exq.size() > 0) ? exq[0].i : 0);
    end
    arm_set(1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_average();
    test_channel_filter();
    test_random_avg();
    test_back_to_back();
    test_abort_rearm();
    test_clamp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
